// File: rtl/multi_debouncer.sv
// rtl/multi_debouncer.sv - N-channel button debouncer with level, press and release outputs
// Optional auto-repeat of btn_press while held: define AUTOREPEAT_EN.
module multi_debouncer #(
    parameter int CHANNELS       = 5,
    parameter int TICK_DIV       = 12500,
    parameter int STABLE_SAMPLES = 4,
    parameter int ACTIVE_LOW     = 0,
    parameter int REPEAT_DELAY   = 50,
    parameter int REPEAT_PERIOD  = 10
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_press,
    output logic [CHANNELS-1:0] btn_release,
    output logic                sample_tick
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = $clog2(STABLE_SAMPLES + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_SAMPLES - 1);

    if (CHANNELS < 1 || TICK_DIV < 2 || STABLE_SAMPLES < 1 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("multi_debouncer: parameter out of range");
    end

    logic [CHANNELS-1:0] in_n;
    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] sync2;
    logic [PW-1:0]       presc;
    logic [CW-1:0]       cnt [CHANNELS];

    assign in_n = (ACTIVE_LOW != 0) ? ~btn_in : btn_in;

`ifdef AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = $clog2(REP_MAX + 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0]       rep [CHANNELS];
    // rep_phase: 0 while waiting for the first repeat, 1 once periodic repeats have begun
    logic [CHANNELS-1:0] rep_phase;
`endif

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            presc       <= '0;
            sample_tick <= 1'b0;
            sync1       <= '0;
            sync2       <= '0;
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
`ifdef AUTOREPEAT_EN
                rep[i] <= '0;
`endif
            end
`ifdef AUTOREPEAT_EN
            rep_phase <= '0;
`endif
        end else begin
            presc       <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
            sample_tick <= (presc == PRESC_LAST);
            sync1       <= in_n;
            sync2       <= sync1;
            btn_press   <= '0;
            btn_release <= '0;

            if (sample_tick) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (sync2[i] != btn_level[i] && cnt[i] == CNT_LAST) begin
                        btn_level[i]   <= sync2[i];
                        btn_press[i]   <= sync2[i];
                        btn_release[i] <= ~sync2[i];
                        cnt[i]         <= '0;
`ifdef AUTOREPEAT_EN
                        rep[i]         <= '0;
                        rep_phase[i]   <= 1'b0;
`endif
                    end else begin
                        // A sample matching the current level restarts qualification
                        if (sync2[i] == btn_level[i])
                            cnt[i] <= '0;
                        else
                            cnt[i] <= cnt[i] + CW'(1);
`ifdef AUTOREPEAT_EN
                        if (btn_level[i]) begin
                            if ((!rep_phase[i] && rep[i] == DELAY_LAST) ||
                                (rep_phase[i] && rep[i] == PERIOD_LAST)) begin
                                btn_press[i] <= 1'b1;
                                rep[i]       <= '0;
                                rep_phase[i] <= 1'b1;
                            end else begin
                                rep[i] <= rep[i] + RW'(1);
                            end
                        end
`endif
                    end
                end
            end
        end
    end

endmodule
